// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb defuse game logic.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DEFUSED  = 2'd2,
    EXPLODED = 2'd3
  } bomb_state_t;

  localparam int TIME_W = 8;
  localparam int STEP_W = 3;

  // Default secret order, three bits per cut, first cut in the low bits: 0, 7, 2, 5.
  localparam logic [11:0] DEFAULT_SEQ = 12'hAB8;

endpackage

// File: rtl/wire_edge_detect.sv
// Rising-edge detector on the debounced wire-cut levels, with multi-cut flag
// and index of the cut wire.
module wire_edge_detect #(
  parameter int N_WIRES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_WIRES-1:0] wire_cut,
  output logic [N_WIRES-1:0] new_cut,
  output logic               multi,
  output logic [2:0]         cut_idx
);

  logic [N_WIRES-1:0] wire_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wire_q <= '0;
    else     wire_q <= wire_cut;
  end

  assign new_cut = wire_cut & ~wire_q;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(new_cut & (new_cut - N_WIRES'(1)));

  always_comb begin
    cut_idx = '0;
    for (int i = 0; i < N_WIRES; i++) begin
      if (new_cut[i]) cut_idx = 3'(i);
    end
  end

endmodule

// File: rtl/bomb_defuse_ctrl.sv
// Game FSM: arms a countdown on start, checks each new wire cut against the
// secret order, and reports defused or exploded until replay.
module bomb_defuse_ctrl
  import bomb_pkg::*;
#(
  parameter int                   N_WIRES   = 8,
  parameter int                   SEQ_LEN   = 4,
  parameter int                   TIME_INIT = 60,
  parameter logic [3*SEQ_LEN-1:0] SEQ       = DEFAULT_SEQ
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic [N_WIRES-1:0] wire_cut,
  input  logic               replay,
  output logic               armed,
  output logic               success,
  output logic               explode,
  output logic [TIME_W-1:0]  time_left,
  output logic [STEP_W-1:0]  step
);

  localparam logic [TIME_W-1:0] T_INIT  = TIME_W'(TIME_INIT);
  localparam logic [STEP_W:0]   LEN_EXT = (STEP_W+1)'(SEQ_LEN);

  bomb_state_t         state, state_nx;
  logic [TIME_W-1:0]   time_nx;
  logic [STEP_W-1:0]   step_nx;
  logic [STEP_W:0]     step_inc;
  logic [N_WIRES-1:0]  new_cut;
  logic                multi;
  logic [2:0]          cut_idx;
  logic [2:0]          exp_wire;

  wire_edge_detect #(.N_WIRES(N_WIRES)) u_edge (
    .clk      (clk),
    .rst      (rst),
    .wire_cut (wire_cut),
    .new_cut  (new_cut),
    .multi    (multi),
    .cut_idx  (cut_idx)
  );

  // Step is one bit wider here so a SEQ_LEN of 8 is still detectable.
  assign step_inc = (STEP_W+1)'(step) + (STEP_W+1)'(1);

  always_comb begin
    exp_wire = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (STEP_W'(k) == step) exp_wire = SEQ[3*k +: 3];
    end
  end

  always_comb begin
    state_nx = state;
    time_nx  = time_left;
    step_nx  = step;
    case (state)
      IDLE: begin
        if (start && !replay && (wire_cut == '0)) begin
          state_nx = ARMED;
          time_nx  = T_INIT;
          step_nx  = '0;
        end
      end
      ARMED: begin
        if ((|new_cut) && (multi || (cut_idx != exp_wire))) begin
          state_nx = EXPLODED;
        end else begin
          if (|new_cut) begin
            step_nx = STEP_W'(step_inc);
            if (step_inc == LEN_EXT) state_nx = DEFUSED;
          end
          // A final correct cut on the last tick still counts as defused.
          if (tick && (time_left != '0)) begin
            time_nx = time_left - TIME_W'(1);
            if ((time_nx == '0) && (state_nx != DEFUSED)) state_nx = EXPLODED;
          end
        end
      end
      DEFUSED, EXPLODED: begin
        if (replay) begin
          state_nx = IDLE;
          time_nx  = T_INIT;
          step_nx  = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      time_left <= T_INIT;
      step      <= '0;
      armed     <= 1'b0;
      success   <= 1'b0;
      explode   <= 1'b0;
    end else begin
      state     <= state_nx;
      time_left <= time_nx;
      step      <= step_nx;
      armed     <= (state_nx == ARMED);
      success   <= (state_nx == DEFUSED);
      explode   <= (state_nx == EXPLODED);
    end
  end

endmodule

// File: tb/tb_bomb_defuse_ctrl.sv
// Self-checking bench: directed scenarios followed by random play, all
// compared against a round-level reference model.
module tb_bomb_defuse_ctrl;

  localparam int NW  = 8;
  localparam int LEN = 4;
  localparam int TI  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          tick;
  logic [NW-1:0] wire_cut;
  logic          replay;
  logic          armed;
  logic          success;
  logic          explode;
  logic [7:0]    time_left;
  logic [2:0]    step;

  bomb_defuse_ctrl #(
    .N_WIRES   (NW),
    .SEQ_LEN   (LEN),
    .TIME_INIT (TI),
    .SEQ       (12'hAB8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tick      (tick),
    .wire_cut  (wire_cut),
    .replay    (replay),
    .armed     (armed),
    .success   (success),
    .explode   (explode),
    .time_left (time_left),
    .step      (step)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: a round is either not running, running, or finished
  // with an outcome; the secret order is kept as a plain list of wires.
  int          seq_q[$] = '{0, 7, 2, 5};
  bit          m_running;
  int          m_outcome;   // 0 none, 1 defused, 2 exploded
  int          m_cuts;
  int          m_time;
  logic [NW-1:0] m_prev;

  logic [13:0] exp_q[$];    // {armed, success, explode, time_left, step}
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 1'b0;
    m_outcome = 0;
    m_cuts    = 0;
    m_time    = TI;
    m_prev    = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [NW-1:0] nc;
    int            n_new;
    int            which;
    nc     = wire_cut & ~m_prev;
    m_prev = wire_cut;
    n_new  = $countones(nc);
    which  = -1;
    for (int i = 0; i < NW; i++) if (nc[i]) which = i;
    if (m_running) begin
      if (n_new > 1 || (n_new == 1 && which != seq_q[m_cuts])) begin
        m_running = 1'b0;
        m_outcome = 2;
      end else begin
        if (n_new == 1) begin
          m_cuts++;
          if (m_cuts == LEN) begin
            m_running = 1'b0;
            m_outcome = 1;
          end
        end
        if (tick) begin
          m_time--;
          if (m_time == 0 && m_outcome != 1) begin
            m_running = 1'b0;
            m_outcome = 2;
          end
        end
      end
    end else if (m_outcome != 0) begin
      if (replay) begin
        m_outcome = 0;
        m_cuts    = 0;
        m_time    = TI;
      end
    end else if (start && !replay && wire_cut == '0) begin
      m_running = 1'b1;
      m_cuts    = 0;
      m_time    = TI;
    end
    exp_q.push_back({m_running, (m_outcome == 1), (m_outcome == 2), 8'(m_time), 3'(m_cuts)});
  endtask

  task automatic compare_outputs();
    logic [13:0] e;
    if (exp_q.size() == 0) begin
      check_eq("exp_queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("armed",     {31'd0, armed},     {31'd0, e[13]});
      check_eq("success",   {31'd0, success},   {31'd0, e[12]});
      check_eq("explode",   {31'd0, explode},   {31'd0, e[11]});
      check_eq("time_left", {24'd0, time_left}, {24'd0, e[10:3]});
      check_eq("step",      {29'd0, step},      {29'd0, e[2:0]});
    end
  endtask

  // Driver tasks
  task automatic step_cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_cycle();
    start = 1'b0;
  endtask

  task automatic cut(input int w, input int gap);
    wire_cut[w] = 1'b1;
    step_cycle();
    idle_cycles(gap);
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step_cycle();
    tick = 1'b0;
  endtask

  task automatic replay_and_clear();
    replay = 1'b1;
    step_cycle();
    replay   = 1'b0;
    wire_cut = '0;
    step_cycle();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    tick     = 1'b0;
    replay   = 1'b0;
    wire_cut = '0;
    model_reset();
    #12;
    check_eq("rst_armed",   {31'd0, armed},   32'd0);
    check_eq("rst_success", {31'd0, success}, 32'd0);
    check_eq("rst_explode", {31'd0, explode}, 32'd0);
    check_eq("rst_time",    {24'd0, time_left}, TI);
    check_eq("rst_step",    {29'd0, step},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    // Normal defuse, cuts three cycles apart, no ticks
    pulse_start();
    check_eq("arm_armed", {31'd0, armed}, 32'd1);
    cut(0, 2);
    cut(7, 2);
    cut(2, 2);
    wire_cut[5] = 1'b1;
    step_cycle();
    check_eq("defuse_success", {31'd0, success}, 32'd1);
    check_eq("defuse_armed",   {31'd0, armed},   32'd0);
    check_eq("defuse_explode", {31'd0, explode}, 32'd0);
    check_eq("defuse_step",    {29'd0, step},    LEN);
    idle_cycles(2);

    // Replay from DEFUSED
    replay = 1'b1;
    step_cycle();
    check_eq("replay_success", {31'd0, success}, 32'd0);
    check_eq("replay_time",    {24'd0, time_left}, TI);
    check_eq("replay_step",    {29'd0, step},    32'd0);
    replay   = 1'b0;
    wire_cut = '0;
    step_cycle();

    // Start refused while a wire is already cut
    wire_cut = 8'h01;
    pulse_start();
    check_eq("refuse_armed", {31'd0, armed}, 32'd0);
    wire_cut = '0;
    step_cycle();

    // Wrong wire
    pulse_start();
    cut(0, 2);
    wire_cut[3] = 1'b1;
    step_cycle();
    check_eq("wrong_explode", {31'd0, explode}, 32'd1);
    check_eq("wrong_step",    {29'd0, step},    32'd1);
    check_eq("wrong_success", {31'd0, success}, 32'd0);
    replay_and_clear();

    // Timeout
    pulse_start();
    for (int i = 0; i < TI; i++) begin
      tick_once();
      check_eq("timeout_time", {24'd0, time_left}, TI - 1 - i);
    end
    check_eq("timeout_explode", {31'd0, explode}, 32'd1);
    check_eq("timeout_armed",   {31'd0, armed},   32'd0);
    idle_cycles(2);
    check_eq("timeout_hold", {24'd0, time_left}, 32'd0);
    replay_and_clear();

    // Two wires cut together
    pulse_start();
    wire_cut = 8'h81;
    step_cycle();
    check_eq("multi_explode", {31'd0, explode}, 32'd1);
    replay_and_clear();

    // Final correct cut on the last tick
    pulse_start();
    for (int i = 0; i < TI - 1; i++) tick_once();
    cut(0, 1);
    cut(7, 1);
    cut(2, 1);
    wire_cut[5] = 1'b1;
    tick = 1'b1;
    step_cycle();
    tick = 1'b0;
    check_eq("race_success", {31'd0, success}, 32'd1);
    check_eq("race_explode", {31'd0, explode}, 32'd0);
    check_eq("race_time",    {24'd0, time_left}, 32'd0);
    replay_and_clear();

    // Asynchronous reset mid-round, between edges
    pulse_start();
    cut(0, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_armed",   {31'd0, armed},   32'd0);
    check_eq("arst_success", {31'd0, success}, 32'd0);
    check_eq("arst_explode", {31'd0, explode}, 32'd0);
    check_eq("arst_time",    {24'd0, time_left}, TI);
    check_eq("arst_step",    {29'd0, step},    32'd0);
    wire_cut = '0;
    model_reset();
    #1 rst = 1'b0;
    idle_cycles(2);

    // Random play
    for (int c = 0; c < 4000; c++) begin
      int r;
      start  = ($urandom_range(0, 5) == 0);
      tick   = ($urandom_range(0, 11) == 0);
      replay = (m_outcome != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 30) == 0);
      if (m_running) begin
        r = $urandom_range(0, 9);
        if (r <= 5)      wire_cut[seq_q[m_cuts]] = 1'b1;
        else if (r == 6) wire_cut[$urandom_range(0, NW-1)] = 1'b1;
        else if (r == 7) wire_cut[$urandom_range(0, NW-1)] = 1'b0;
        else if (r == 8) begin
          wire_cut[$urandom_range(0, NW-1)] = 1'b1;
          wire_cut[$urandom_range(0, NW-1)] = 1'b1;
        end
      end else if (m_outcome == 0) begin
        if ($urandom_range(0, 2) == 0) wire_cut = '0;
      end else if ($urandom_range(0, 4) == 0) begin
        wire_cut[$urandom_range(0, NW-1)] = ~wire_cut[$urandom_range(0, NW-1)];
      end
      step_cycle();
    end
    start  = 1'b0;
    tick   = 1'b0;
    replay = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bomb_defuse_ctrl.md
# bomb_defuse_ctrl

Game-logic stage of the bomb dismantlement game, directly upstream of the LED-matrix face/beeper stage. It arms a countdown on `start`, watches the player's wire-cut switches and checks each new cut against a fixed secret order. It produces the level `success` that the face stage consumes, or `explode` on a wrong cut or timeout. The face stage's repeat request returns it to idle for a new round.

## Interface
- `N_WIRES`, 8: number of cut-able wires; must be ≤ 8.
- `SEQ_LEN`, 4: number of cuts required to defuse; 1..8.
- `TIME_INIT`, 60: countdown start value in ticks; 1..255.
- `SEQ`, 12'hAB8: secret order. Cut k must be wire `SEQ[3k+2:3k]`. The default order is 0, 7, 2, 5.

- `clk` in 1: system clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: single-cycle request to arm a round.
- `tick` in 1: single-cycle 1 Hz enable from the prescaler.
- `wire_cut` in N_WIRES: debounced switch levels, 1 = wire cut.
- `replay` in 1: round restart request, driven by the face stage's repeat output; level.
- `armed` out 1: high while the countdown runs.
- `success` out 1: held high in DEFUSED; feeds the face stage.
- `explode` out 1: held high in EXPLODED.
- `time_left` out 8: remaining ticks, unsigned.
- `step` out 3: number of correct cuts so far.

## Operation
- States: IDLE, ARMED, DEFUSED, EXPLODED. All outputs are registered.
- Reset values:
  - state = IDLE
  - `armed` = `success` = `explode` = 0
  - `step` = 0
  - `time_left` = TIME_INIT
  - `wire_q` = 0
- Edge detect:
  - `wire_q` registers `wire_cut` every cycle, in every state.
  - `new_cut = wire_cut & ~wire_q`.
- IDLE:
  - On `start=1`, `replay=0` and `wire_cut==0`, go to ARMED with `time_left`=TIME_INIT and `step`=0.
  - `start` while any wire is already cut is ignored; stay in IDLE.
- ARMED, evaluated in priority order each cycle:
  1. `new_cut` has more than one bit set, or its single bit ≠ `SEQ[step]`: go to EXPLODED.
  2. `new_cut` is the single correct bit: `step`+1. If that reaches SEQ_LEN, go to DEFUSED.
  3. `tick=1`: `time_left`−1. If the result is 0 and the state is not entering DEFUSED, go to EXPLODED.
- Simultaneous events:
  - A final correct cut and the last tick in the same cycle: DEFUSED wins.
  - A wrong cut and a tick in the same cycle: EXPLODED.
- Frozen values: `time_left` and `step` freeze when ARMED is left.
- Re-cutting: a wire re-connected and re-cut produces a new edge and is judged again.
- DEFUSED and EXPLODED:
  - Hold all outputs.
  - `replay=1` returns to IDLE and clears `success`, `explode` and `step`. `time_left` is restored to TIME_INIT.
- `start` outside IDLE is ignored.
- Reset mid-round: immediate return to the reset values, with no pending effects.

## Timing
- `start` sampled at edge t: `armed`=1 from t+1.
- `wire_cut` rising at edge t: `step`, `success` and `explode` update at t+1. This is one-cycle latency; there is no extra synchroniser, since the inputs are already debounced.
- `tick` at t with `time_left`=1: `time_left`=0, `explode`=1 and `armed`=0 at t+1.
- `replay` sampled at t: state is IDLE at t+1. A `start` arriving at t+1 is accepted only if `replay` has been released by then.
- `time_left` never wraps below 0. `step` never exceeds SEQ_LEN.

## Structure
- Package `bomb_pkg`, containing:
  - state enum `bomb_state_t` (IDLE, ARMED, DEFUSED, EXPLODED)
  - `TIME_W`=8
  - `STEP_W`=3
  - the default `SEQ` constant
- One sub-module, `wire_edge_detect`, parameterised by N_WIRES.
  - Holds `wire_q`.
  - Outputs `new_cut`, a `multi` flag (more than one bit set) and the encoded index of a single cut.
- The FSM, countdown and sequence checker live in `bomb_defuse_ctrl`.

## Test plan
- Normal defuse: reset, pulse `start`, then cut wires 0, 7, 2, 5 at least 3 cycles apart with no ticks. Require `step` 1, 2, 3, then `success`=1 and `armed`=0 one cycle after the cut of wire 5. `explode` stays 0.
- Wrong wire: arm, cut wire 0, then wire 3. Require `explode`=1 one cycle after the cut of wire 3, with `step` frozen at 1 and `success`=0.
- Timeout: arm with TIME_INIT=3 and apply 3 ticks. Require `time_left` 2, 1, 0, with `explode`=1 in the same cycle `time_left` reaches 0.
- Simultaneous events:
  - Two wires cut in the same cycle gives EXPLODED.
  - With TIME_INIT=1, the final correct cut together with a tick gives `success`=1, `explode`=0 and `time_left`=0.
- Start refusal and replay:
  - `start` with `wire_cut`=8'h01 leaves `armed`=0.
  - From DEFUSED, `replay`=1 gives IDLE next cycle, with `success`=0 and `time_left`=TIME_INIT.
- Async reset: assert `rst` mid-round between clock edges. Require all outputs at their reset values immediately, without waiting for a clock edge.
